arbitrated_requester: RTL and testbench
=======================================

Name: arbitrated_requester

Overview:
- Requestor-side endpoint for the priority and round-robin arbiters. It wraps a local ready/valid source.
- It raises and holds one bit of the arbiter request vector and waits for the matching grant bit. It then passes one burst onto the shared (one-hot-muxed) path and drops the request when the burst is done.
- Outputs are zero while not granted, so several instances can be OR-combined or fed to a one-hot multiplexer.

Parameters:
- WORD_WIDTH, 8, data width of local and shared paths.
- MAX_BEATS, 16, maximum accepted beats per grant. Must be >= 1.
- COUNT_WIDTH, 5, beat counter width. Must hold MAX_BEATS.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  local source has a beat; held until accepted.
- in_ready  output  1  local beat accepted when in_valid & in_ready.
- in_data  input  WORD_WIDTH  local beat data.
- in_last  input  1  local beat ends the burst.
- request  output  1  registered request to the arbiter (one bit of its request vector).
- grant  input  1  this requestor's bit of the arbiter grant vector (combinational from the arbiter).
- out_valid  output  1  shared-path beat valid.
- out_ready  input  1  shared-path sink ready.
- out_data  output  WORD_WIDTH  shared-path data. Zero when not in TRANSFER.
- out_last  output  1  last beat of this grant.
- busy  output  1  high in REQUEST or TRANSFER.
- error  output  1  sticky: grant was lost mid-burst.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream): state IDLE, request 0, beat count 0, error 0.
- While reset is asserted, all outputs are 0. Asserting reset mid-burst aborts the burst immediately, with no release cycle.
- IDLE: request 0.
  - in_valid=1 -> REQUEST. The request register goes to 1 on the same edge.
- REQUEST: request 1, in_ready 0, out_valid 0.
  - grant=1 -> TRANSFER on the next edge. The count clears to 0.
  - grant is ignored in every state other than REQUEST and TRANSFER.
- TRANSFER: request 1.
  - Pass-through: out_valid=in_valid, in_ready=out_ready, out_data=in_data.
  - out_last = in_last | (count == MAX_BEATS-1).
  - A beat is accepted when in_valid & out_ready. Each accepted beat increments the count.
  - Bubbles (in_valid=0) keep request held; no timeout.
  - On an accepted beat with out_last=1 -> RELEASE. The request register drops to 0 on that edge.
  - The local source is not told when its burst was truncated by MAX_BEATS. Remaining data simply forms the next burst.
  - grant=0 while in TRANSFER:
    - In that cycle out_valid=0, in_ready=0, out_data=0, and no beat is accepted.
    - error is set to 1 (sticky until reset); state -> RELEASE.
- RELEASE: request 0 for exactly one cycle so the arbiter can rotate.
  - in_valid=1 -> REQUEST; otherwise -> IDLE.
- Outside TRANSFER: in_ready=0, out_valid=0, out_data=0, out_last=0.
- Latency, best case (in_valid rises in IDLE at cycle 0):
  - request=1 at cycle 1.
  - With grant at cycle 1, the first beat can transfer at cycle 2.
  - Minimum request-low gap between back-to-back bursts: 1 cycle.
- busy = (state==REQUEST) | (state==TRANSFER).
- Simultaneous events:
  - in_last and the MAX_BEATS limit on the same beat: a single burst end.
  - grant drop and out_ready=1 on the same cycle: no beat accepted; error path taken.
- Counter never wraps: it is cleared on entry to TRANSFER and the burst ends at MAX_BEATS.

Test Plan:
- Reset mid-TRANSFER (MAX_BEATS=16, 3 beats accepted) -> all outputs 0 immediately; after release, state IDLE, error 0.
- in_valid=1 in IDLE at cycle 0, grant tied 1 -> request=1 at cycle 1; beats 0xA1,0xA2 (last on 0xA2) appear on out_data at cycles 2,3 with out_last only on 0xA2; request=0 at cycle 4; out_data=0 from cycle 4.
- grant held 0 for 10 cycles after request -> in_ready=0, out_valid=0 and request=1 throughout. Grant at cycle 11 -> first beat at cycle 12.
- MAX_BEATS=4, stream of 6 beats without in_last -> out_last on beat 4; one cycle with request=0; re-request; beats 5-6 form a second burst.
- out_ready toggling 1,0,1,0 with in_valid held -> each beat accepted exactly once, no duplicated or dropped data.
- grant dropped after 2 beats -> out_valid=0 that cycle, error=1 and stays 1, request=0 next cycle; next burst proceeds normally with error still 1.

Source files
------------

// File: rtl/arbitrated_requester.sv
// Requestor-side arbiter endpoint: holds one request bit, forwards one burst per grant
// onto a shared one-hot-muxed path, and keeps every output at zero while not granted.
module arbitrated_requester #(
  parameter int WORD_WIDTH  = 8,
  parameter int MAX_BEATS   = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  request,
  input  logic                  grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    TRANSFER = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(MAX_BEATS - 1);

  state_e                 state_q, state_d;
  logic                   request_q, request_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      request_q <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    count_d   = count_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = REQUEST;
      end
      REQUEST: begin
        if (grant) begin
          state_d = TRANSFER;
          count_d = '0;
        end
      end
      TRANSFER: begin
        if (grant) begin
          out_valid = in_valid;
          in_ready  = out_ready;
          out_data  = in_data;
          out_last  = in_last | (count_q == LAST_CNT);
          accept    = in_valid & out_ready;
          if (accept) begin
            count_d = count_q + COUNT_WIDTH'(1);
            if (out_last) state_d = RELEASE;
          end
        end else begin
          // Grant lost mid-burst: drive nothing this cycle and give up the slot.
          error_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = in_valid ? REQUEST : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Request register tracks the state being entered, so it rises/falls on the same edge.
    request_d = (state_d == REQUEST) | (state_d == TRANSFER);
  end

  assign request = request_q;
  assign busy    = (state_q == REQUEST) | (state_q == TRANSFER);
  assign error   = error_q;

endmodule

// File: tb/tb_arbitrated_requester.sv
// Directed bench for arbitrated_requester: a MAX_BEATS=16 instance and a MAX_BEATS=4
// instance share stimulus; each step checks hand-computed outputs.
module tb_arbitrated_requester;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, grant = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       ir16, r16, ov16, ol16, b16, e16;
  logic [7:0] od16;
  logic       ir4, r4, ov4, ol4, b4, e4;
  logic [7:0] od4;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  arbitrated_requester #(.WORD_WIDTH(8), .MAX_BEATS(16), .COUNT_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir16),
    .in_data(in_data), .in_last(in_last), .request(r16), .grant(grant),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_last(ol16),
    .busy(b16), .error(e16));

  arbitrated_requester #(.WORD_WIDTH(8), .MAX_BEATS(4), .COUNT_WIDTH(3)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .in_last(in_last), .request(r4), .grant(grant),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4),
    .busy(b4), .error(e4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic l,
                     input logic g, input logic r);
    in_valid = v; in_data = d; in_last = l; grant = g; out_ready = r;
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drv(0, 8'h00, 0, 0, 0);
    next_cyc();
    reset_n = 1'b1;
    next_cyc();
  endtask

  task automatic chk_quiet16(input string tag);
    chk({tag, ".req"},   r16,  1'b0);
    chk({tag, ".irdy"},  ir16, 1'b0);
    chk({tag, ".ovld"},  ov16, 1'b0);
    chk({tag, ".odata"}, od16, 8'h00);
    chk({tag, ".olast"}, ol16, 1'b0);
    chk({tag, ".busy"},  b16,  1'b0);
    chk({tag, ".err"},   e16,  1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with active-looking inputs: everything must stay zero.
    drv(1, 8'h5A, 1, 1, 1);
    chk_quiet16("rst");
    next_cyc();
    chk_quiet16("rst2");

    // Best-case latency, grant tied high, two-beat burst.
    do_reset();
    drv(1, 8'hA1, 0, 1, 1);
    chk("lat.c0.req", r16, 1'b0);
    chk("lat.c0.busy", b16, 1'b0);
    next_cyc();
    drv(1, 8'hA1, 0, 1, 1);
    chk("lat.c1.req", r16, 1'b1);
    chk("lat.c1.busy", b16, 1'b1);
    chk("lat.c1.ovld", ov16, 1'b0);
    chk("lat.c1.irdy", ir16, 1'b0);
    chk("lat.c1.odata", od16, 8'h00);
    next_cyc();
    drv(1, 8'hA1, 0, 1, 1);
    chk("lat.c2.ovld", ov16, 1'b1);
    chk("lat.c2.odata", od16, 8'hA1);
    chk("lat.c2.olast", ol16, 1'b0);
    chk("lat.c2.irdy", ir16, 1'b1);
    next_cyc();
    drv(1, 8'hA2, 1, 1, 1);
    chk("lat.c3.odata", od16, 8'hA2);
    chk("lat.c3.olast", ol16, 1'b1);
    next_cyc();
    drv(0, 8'h00, 0, 1, 1);
    chk("lat.c4.req", r16, 1'b0);
    chk("lat.c4.odata", od16, 8'h00);
    chk("lat.c4.olast", ol16, 1'b0);
    chk("lat.c4.busy", b16, 1'b0);
    next_cyc();
    chk("lat.c5.req", r16, 1'b0);
    chk("lat.c5.busy", b16, 1'b0);

    // Grant withheld for 10 cycles after request.
    drv(1, 8'hE1, 1, 0, 1);
    chk("wait.c0.req", r16, 1'b0);
    next_cyc();
    for (int i = 1; i <= 10; i++) begin
      drv(1, 8'hE1, 1, 0, 1);
      chk($sformatf("wait.c%0d.req", i), r16, 1'b1);
      chk($sformatf("wait.c%0d.irdy", i), ir16, 1'b0);
      chk($sformatf("wait.c%0d.ovld", i), ov16, 1'b0);
      chk($sformatf("wait.c%0d.err", i), e16, 1'b0);
      next_cyc();
    end
    drv(1, 8'hE1, 1, 1, 1);
    chk("wait.c11.ovld", ov16, 1'b0);
    chk("wait.c11.req", r16, 1'b1);
    next_cyc();
    drv(1, 8'hE1, 1, 1, 1);
    chk("wait.c12.ovld", ov16, 1'b1);
    chk("wait.c12.odata", od16, 8'hE1);
    chk("wait.c12.olast", ol16, 1'b1);
    next_cyc();
    drv(0, 8'h00, 0, 1, 1);
    chk("wait.c13.req", r16, 1'b0);
    next_cyc();

    // MAX_BEATS=4 truncation: 6 beats without in_last split 4 + 2.
    do_reset();
    drv(1, 8'hB1, 0, 1, 1);
    chk("max4.c0.req", r4, 1'b0);
    next_cyc();
    drv(1, 8'hB1, 0, 1, 1);
    chk("max4.c1.req", r4, 1'b1);
    chk("max4.c1.ovld", ov4, 1'b0);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      drv(1, 8'hB1 + 8'(k), 0, 1, 1);
      chk($sformatf("max4.b%0d.odata", k + 1), od4, 8'hB1 + 8'(k));
      chk($sformatf("max4.b%0d.olast", k + 1), ol4, (k == 3) ? 1'b1 : 1'b0);
      next_cyc();
    end
    drv(1, 8'hB5, 0, 1, 1);
    chk("max4.rel.req", r4, 1'b0);
    chk("max4.rel.ovld", ov4, 1'b0);
    next_cyc();
    drv(1, 8'hB5, 0, 1, 1);
    chk("max4.rereq.req", r4, 1'b1);
    chk("max4.rereq.ovld", ov4, 1'b0);
    next_cyc();
    drv(1, 8'hB5, 0, 1, 1);
    chk("max4.b5.ovld", ov4, 1'b1);
    chk("max4.b5.odata", od4, 8'hB5);
    chk("max4.b5.olast", ol4, 1'b0);
    next_cyc();
    drv(1, 8'hB6, 1, 1, 1);
    chk("max4.b6.odata", od4, 8'hB6);
    chk("max4.b6.olast", ol4, 1'b1);
    next_cyc();
    drv(0, 8'h00, 0, 1, 1);
    chk("max4.end.req", r4, 1'b0);
    next_cyc();

    // out_ready toggling: stalled beats are neither dropped nor counted twice.
    do_reset();
    drv(1, 8'hC1, 0, 1, 1);
    next_cyc();
    drv(1, 8'hC1, 0, 1, 1);
    next_cyc();
    for (int i = 0; i < 7; i++) begin
      logic [7:0] d;
      logic       rdy;
      d   = 8'hC1 + 8'((i + 1) / 2);
      rdy = (i % 2 == 0);
      drv(1, d, 0, 1, rdy);
      chk($sformatf("tog.%0d.ovld", i), ov16, 1'b1);
      chk($sformatf("tog.%0d.odata", i), od16, d);
      chk($sformatf("tog.%0d.irdy", i), ir16, rdy);
      chk($sformatf("tog.%0d.odata4", i), od4, d);
      chk($sformatf("tog.%0d.olast4", i), ol4, (d == 8'hC4) ? 1'b1 : 1'b0);
      next_cyc();
    end
    drv(0, 8'h00, 0, 1, 1);
    chk("tog.end.req4", r4, 1'b0);
    chk("tog.end.req16", r16, 1'b1);
    chk("tog.end.ovld16", ov16, 1'b0);
    next_cyc();

    // Grant lost after two beats.
    do_reset();
    drv(1, 8'hD1, 0, 1, 1);
    next_cyc();
    drv(1, 8'hD1, 0, 1, 1);
    next_cyc();
    drv(1, 8'hD1, 0, 1, 1);
    chk("gdrop.b1.odata", od16, 8'hD1);
    next_cyc();
    drv(1, 8'hD2, 0, 1, 1);
    chk("gdrop.b2.odata", od16, 8'hD2);
    next_cyc();
    drv(1, 8'hD3, 0, 0, 1);
    chk("gdrop.c4.ovld", ov16, 1'b0);
    chk("gdrop.c4.irdy", ir16, 1'b0);
    chk("gdrop.c4.odata", od16, 8'h00);
    chk("gdrop.c4.err", e16, 1'b0);
    chk("gdrop.c4.req", r16, 1'b1);
    next_cyc();
    drv(1, 8'hD3, 1, 1, 1);
    chk("gdrop.c5.req", r16, 1'b0);
    chk("gdrop.c5.err", e16, 1'b1);
    chk("gdrop.c5.ovld", ov16, 1'b0);
    next_cyc();
    drv(1, 8'hD3, 1, 1, 1);
    chk("gdrop.c6.req", r16, 1'b1);
    chk("gdrop.c6.err", e16, 1'b1);
    next_cyc();
    drv(1, 8'hD3, 1, 1, 1);
    chk("gdrop.c7.ovld", ov16, 1'b1);
    chk("gdrop.c7.odata", od16, 8'hD3);
    chk("gdrop.c7.olast", ol16, 1'b1);
    chk("gdrop.c7.err", e16, 1'b1);
    next_cyc();
    drv(0, 8'h00, 0, 1, 1);
    chk("gdrop.c8.req", r16, 1'b0);
    chk("gdrop.c8.err", e16, 1'b1);
    next_cyc();
    chk("gdrop.c9.err", e16, 1'b1);
    chk("gdrop.c9.busy", b16, 1'b0);

    // Reset asserted mid-TRANSFER after 3 accepted beats.
    do_reset();
    drv(1, 8'hF1, 0, 1, 1);
    next_cyc();
    drv(1, 8'hF1, 0, 1, 1);
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      drv(1, 8'hF1 + 8'(k), 0, 1, 1);
      chk($sformatf("mrst.b%0d.odata", k + 1), od16, 8'hF1 + 8'(k));
      next_cyc();
    end
    drv(1, 8'hF4, 0, 1, 1);
    chk("mrst.pre.ovld", ov16, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_quiet16("mrst.in");
    next_cyc();
    drv(0, 8'h00, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk_quiet16("mrst.out");
    next_cyc();
    chk("mrst.idle.busy", b16, 1'b0);
    chk("mrst.idle.req", r16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
